dmem_ctrl: RTL

Parametrised single-port data memory for the processor datapath. It replaces the combinational, unclocked data RAM with a clocked block that has the following features:
- valid/ready request handshake with a registered 1-cycle read response;
- per-byte write enables;
- alignment and range error reporting;
- a hardware clear-on-reset sequencer.

It sits between the load/store stage and the on-chip RAM array.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_array.sv | 62 ++++++
 rtl/dmem_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and width helpers for the data-memory controller.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package dmem_pkg;

  // Widest data word the response bundle can carry.
  localparam int RSP_MAX_W = 64;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_t;

  // Byte-offset bits inside one data word.
  function automatic int calc_ofs_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index bits for the array depth.
  function automatic int calc_idx_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [RSP_MAX_W-1:0] rdata;
  } dmem_rsp_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word storage with byte-enable merge and registered read.
// Latency: a write updates the word on the edge; read data is valid the cycle after the read edge.
// Backpressure: none; one access per cycle, and the caller never asserts we and re together.
// Ports: clk; we/re strobes; idx word index; wdata/be write data and byte enables;
//        rdata registered read data (held while re=0).
// With DMEM_PARITY_EN defined: par_flip inverts the stored parity bit on a write,
//        par_err flags a parity mismatch on the registered read.
module dmem_array import dmem_pkg::*; #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 128,
  localparam int IDX_W  = calc_idx_w(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
`ifdef DMEM_PARITY_EN
  input  logic              par_flip,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] merged;

  assign cur_word = mem_q[idx];

  // Whole word is rewritten with the enabled bytes replaced, so the parity
  // bit always covers exactly what ends up stored.
  always_comb begin
    merged = cur_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= merged;
    if (re) rdata_q <= cur_word;
  end

  assign rdata = rdata_q;

`ifdef DMEM_PARITY_EN
  logic par_q [DEPTH];
  logic par_err_q;

  always_ff @(posedge clk) begin
    if (we) par_q[idx] <= (^merged) ^ par_flip;
    if (re) par_err_q <= (^cur_word) ^ par_q[idx];
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: clocked data memory with request handshake, error decode and clear-on-reset.
// Latency: every accepted request gets a one-cycle rsp_valid pulse exactly one cycle later.
// Backpressure: req_ready is low only while clearing; responses cannot be stalled.
// Ports: clk, reset_n (async, active low); req_valid/req_ready/req_we/req_addr/req_wdata/req_be
//        request side; rsp_valid/rsp_rdata/rsp_err response side; init_busy while clearing.
// Optional macro DMEM_PARITY_EN adds per-word even parity and the inj_par_flip test input.
module dmem_ctrl import dmem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
`ifdef DMEM_PARITY_EN
  input  logic                  inj_par_flip,
`endif
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int OFS_W = calc_ofs_w(DATA_W);
  localparam int IDX_W = calc_idx_w(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << OFS_W) - 64'd1);

  // Request decode
  logic             misaligned;
  logic             out_of_range;
  logic             req_err;
  logic             accept;
  logic [IDX_W-1:0] req_idx;

  // State and response flops
  dmem_state_t      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_busy_q, init_busy_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  // Last response was a successful read: rdata comes from the array, else 0.
  logic             rd_ok_q, rd_ok_d;

  // Array port
  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_wdata;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_rdata;
`ifdef DMEM_PARITY_EN
  logic              arr_flip;
  logic              arr_par_err;
`endif

  assign misaligned   = (req_addr & ALIGN_MASK) != '0;
  assign out_of_range = (req_addr >> (OFS_W + IDX_W)) != '0;
  assign req_err      = misaligned | out_of_range;
  assign req_idx      = req_addr[OFS_W +: IDX_W];
  assign accept       = req_valid & req_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_busy_d = init_busy_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rd_ok_d     = rd_ok_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d     = RUN;
          init_busy_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = req_err;
          rd_ok_d     = ~req_we & ~req_err;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  // The clear sequence owns the array port while INIT; errored requests never touch it.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_idx   = req_idx;
    arr_wdata = req_wdata;
    arr_be    = req_be;
`ifdef DMEM_PARITY_EN
    arr_flip  = inj_par_flip;
`endif
    if (state_q == INIT) begin
      arr_we    = 1'b1;
      arr_idx   = cnt_q;
      arr_wdata = '0;
      arr_be    = '1;
`ifdef DMEM_PARITY_EN
      arr_flip  = 1'b0;
`endif
    end else if (accept && !req_err) begin
      arr_we = req_we;
      arr_re = ~req_we;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk      (clk),
    .we       (arr_we),
    .re       (arr_re),
    .idx      (arr_idx),
    .wdata    (arr_wdata),
    .be       (arr_be),
`ifdef DMEM_PARITY_EN
    .par_flip (arr_flip),
    .par_err  (arr_par_err),
`endif
    .rdata    (arr_rdata)
  );

  // Response bundle; rdata/err hold between pulses because both the flags and
  // the array read register only change on an accepted request.
  dmem_rsp_t rsp;

  always_comb begin
    rsp       = '0;
    rsp.valid = rsp_valid_q;
`ifdef DMEM_PARITY_EN
    rsp.err   = rsp_err_q | (rd_ok_q & arr_par_err);
`else
    rsp.err   = rsp_err_q;
`endif
    rsp.rdata = rd_ok_q ? RSP_MAX_W'(arr_rdata) : '0;
  end

  generate
    if (DATA_W < RSP_MAX_W) begin : g_rsp_hi
      logic unused_rsp_hi;
      assign unused_rsp_hi = ^rsp.rdata[RSP_MAX_W-1:DATA_W];
    end
  endgenerate

  assign req_ready = req_ready_q;
  assign init_busy = init_busy_q;
  assign rsp_valid = rsp.valid;
  assign rsp_err   = rsp.err;
  assign rsp_rdata = rsp.rdata[DATA_W-1:0];

endmodule
